// File: rtl/bus_interconnect.sv
// bus_interconnect: single-master bus decode to RAM / peripheral window with lane alignment and error completion
module bus_interconnect #(
  parameter logic [31:0] RAM_BASE = 32'h0000_0000,
  parameter int          RAM_AW   = 14,
  parameter logic [31:0] PER_BASE = 32'h1000_0000,
  parameter logic [31:0] PER_SIZE = 32'h0000_1000,
  parameter int          TIMEOUT  = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bus_DV,
  input  logic [2:0]        i_bhw,
  input  logic [31:0]       i_bus_address,
  input  logic [31:0]       i_bus_data,
  input  logic              i_write_notread,
  output logic              o_bus_DV,
  output logic [31:0]       o_bus_data,
  output logic              o_bus_error,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [3:0]        o_ram_be,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata,
  output logic              o_per_req,
  output logic              o_per_we,
  output logic [31:0]       o_per_addr,
  output logic [3:0]        o_per_be,
  output logic [31:0]       o_per_wdata,
  input  logic              i_per_ack,
  input  logic [31:0]       i_per_rdata
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, RAM_ACC, RAM_DATA, PER_WAIT, RESP} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [31:0] ram_off, per_off, mask, mask_q, addr_q, wdata_q, resp_d, bus_data;
  logic [4:0] sh, sh_q;
  logic [3:0] be, be_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic ram_hit, per_hit, bad, we_q, lat, load_resp, err_d, bus_err;
  assign ram_off = i_bus_address - RAM_BASE;
  assign per_off = i_bus_address - PER_BASE;
  assign ram_hit = (ram_off >> (RAM_AW + 2)) == 32'd0;
  assign per_hit = per_off < PER_SIZE;
  assign bad = !(i_bhw == 3'b001 || i_bhw == 3'b010 || i_bhw == 3'b100)
             || (i_bhw[1] && i_bus_address[0]) || (i_bhw[2] && |i_bus_address[1:0]);
  assign sh = i_bhw[0] ? {i_bus_address[1:0], 3'b000} : i_bhw[1] ? {i_bus_address[1], 4'b0000} : 5'd0;
  assign be = i_bhw[0] ? 4'b0001 << i_bus_address[1:0]
            : i_bhw[1] ? 4'b0011 << {i_bus_address[1], 1'b0} : 4'b1111;
  assign mask = i_bhw[0] ? 32'h0000_00FF : i_bhw[1] ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  always_ff @(posedge i_clk) begin
    state <= i_rst ? IDLE : next;
    cnt <= (!i_rst && state == PER_WAIT) ? cnt + CW'(1) : '0;
  end
  always_comb begin
    next = state;
    lat = 1'b0;
    load_resp = 1'b0;
    err_d = 1'b0;
    resp_d = 32'd0;
    case (state)
      IDLE: if (i_bus_DV) begin
        lat = !bad && (ram_hit || per_hit);
        load_resp = !lat;
        err_d = !lat;
        next = !lat ? RESP : ram_hit ? RAM_ACC : PER_WAIT;
      end
      RAM_ACC: next = RAM_DATA;
      RAM_DATA: begin
        next = RESP;
        load_resp = 1'b1;
        resp_d = we_q ? 32'd0 : (i_ram_rdata >> sh_q) & mask_q;
      end
      PER_WAIT: if (i_per_ack) begin
        next = RESP;
        load_resp = 1'b1;
        resp_d = we_q ? 32'd0 : (i_per_rdata >> sh_q) & mask_q;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        next = RESP;
        load_resp = 1'b1;
        err_d = 1'b1;
      end
      RESP: next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      sh_q <= '0;
      mask_q <= '0;
      we_q <= 1'b0;
      ram_addr_q <= '0;
      bus_data <= '0;
      bus_err <= 1'b0;
    end else begin
      if (lat) begin
        addr_q <= i_bus_address;
        wdata_q <= i_bus_data << sh;
        be_q <= be;
        sh_q <= sh;
        mask_q <= mask;
        we_q <= i_write_notread;
        ram_addr_q <= ram_off[RAM_AW+1:2];
      end
      if (load_resp) begin
        bus_data <= resp_d;
        bus_err <= err_d;
      end
    end
  end
  assign o_bus_DV = state == RESP;
  assign o_bus_data = bus_data;
  assign o_bus_error = bus_err;
  assign o_ram_en = state == RAM_ACC;
  assign o_ram_we = o_ram_en && we_q;
  assign o_ram_addr = ram_addr_q;
  assign o_ram_be = be_q;
  assign o_ram_wdata = wdata_q;
  assign o_per_req = state == PER_WAIT;
  assign o_per_we = o_per_req && we_q;
  assign o_per_addr = addr_q;
  assign o_per_be = be_q;
  assign o_per_wdata = wdata_q;
endmodule

// File: doc/bus_interconnect.md
# bus_interconnect

Single-master memory bus interconnect sitting directly downstream of the CPU load/store unit. Accepts one byte/half/word request at a time (instruction fetch, load, store, AMO phases all arrive on the same port), decodes the address to on-chip RAM or the peripheral window, performs byte-lane alignment, and returns exactly one completion pulse with right-aligned read data. Misaligned, malformed, unmapped and timed-out accesses complete with an error flag so the CPU never hangs.

## Interface
Parameters:
- RAM_BASE, 32'h0000_0000, byte base address of RAM window
- RAM_AW, 14, RAM word-address width (window = 4·2^RAM_AW bytes)
- PER_BASE, 32'h1000_0000, byte base of peripheral window
- PER_SIZE, 32'h0000_1000, peripheral window size in bytes (power of two)
- TIMEOUT, 256, max cycles to wait for i_per_ack (≥2)

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_bus_DV  in  1  request strobe, one cycle
- i_bhw  in  3  size: 001 byte, 010 half, 100 word
- i_bus_address  in  32  byte address
- i_bus_data  in  32  write data, right-aligned
- i_write_notread  in  1  1 = write
- o_bus_DV  out  1  completion pulse, one cycle
- o_bus_data  out  32  read data, right-aligned, zero-filled above size
- o_bus_error  out  1  valid with o_bus_DV
- o_ram_en, o_ram_we  out  1  RAM enable / write enable
- o_ram_addr  out  RAM_AW  RAM word address
- o_ram_be  out  4  byte enables
- o_ram_wdata  out  32  lane-shifted write data
- i_ram_rdata  in  32  RAM read word, valid the cycle after o_ram_en is sampled
- o_per_req, o_per_we  out  1  peripheral request (level) / write
- o_per_addr  out  32  byte address, unmodified
- o_per_be, o_per_wdata  out  4 / 32  same lane encoding as RAM
- i_per_ack  in  1  one-cycle acknowledge; i_per_rdata valid same cycle
- i_per_rdata  in  32  peripheral read word

## Operation
- FSM: IDLE, RAM_ACC, RAM_DATA, PER_WAIT, RESP.
- IDLE, i_bus_DV=1: check then decode.
  - Error if i_bhw not in {001,010,100}; half with addr[0]=1; word with addr[1:0]≠0; address in neither window → RESP with error=1, data 0; no RAM/peripheral activity.
  - RAM hit → RAM_ACC, o_ram_en=1 one cycle, o_ram_addr = (addr−RAM_BASE)[RAM_AW+1:2].
  - Peripheral hit → PER_WAIT, o_per_req=1.
- Lanes: byte be=0001<<addr[1:0], wdata=data<<8·addr[1:0]; half be=0011<<2·addr[1], wdata=data<<16·addr[1]; word be=1111. Read: rdata>>same shift, masked to 8/16/32 bits (no sign extension; done by load/store).
- RAM_ACC → RAM_DATA → capture i_ram_rdata (reads) → RESP. Writes follow same path, data 0.
- PER_WAIT: o_per_req held until i_per_ack sampled; capture i_per_rdata, drop req, → RESP. Cycle counter reaches TIMEOUT without ack → drop req, RESP with error=1, data 0.
- RESP: o_bus_DV=1 one cycle, o_bus_data/o_bus_error valid and held until next completion → IDLE.
- i_bus_DV outside IDLE: ignored (one outstanding request by protocol). i_per_ack outside PER_WAIT: ignored.

## Timing
- Reset: all outputs 0, FSM IDLE, counter 0. Reset mid-transaction aborts; no o_bus_DV is produced for the aborted request; o_per_req drops the cycle after reset is sampled.
- Request sampled at edge N. Error: o_bus_DV high cycle N+1. RAM read/write: o_ram_en high cycle N+1, o_bus_DV high cycle N+3.
- Peripheral: o_per_req high from N+1; ack sampled at edge M → o_bus_DV high cycle M+1 (M+2 from RESP register).
- Timeout: ack on the same edge the counter hits TIMEOUT wins (normal completion).
- o_bus_DV never two consecutive cycles; minimum request-to-request spacing honoured by requester.

## Test plan
- LW 0x0000_0010, RAM word 0x11223344 → o_ram_en at N+1, addr 4, be 1111; o_bus_DV at N+3, data 0x11223344, error 0.
- LB addr 0x13 with RAM word 0xA1B2C3D4 → data 0x000000A1; SH data 0x0000BEEF at 0x12 → be 1100, wdata 0xBEEF0000.
- LW 0x0000_0002 and LH 0x0000_0001 and bhw=011 → o_bus_DV at N+1, error 1, data 0, o_ram_en never asserted.
- Peripheral SW 0x1000_0004 data 0x55, ack after 5 cycles → req high 5 cycles, we 1; o_bus_DV one cycle after ack, error 0.
- Peripheral read, ack never arrives, TIMEOUT=8 → req drops after 8 cycles, o_bus_DV with error 1, data 0.
- Reset asserted during PER_WAIT → req 0 next cycle, no o_bus_DV; next RAM read completes normally.
